// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store bus between the core data port and dmem_responder
//
// Purpose: bundles the req/ack word-access handshake.
// Signals:
//   req    request valid, held until ack
//   we     1 = write, 0 = read
//   addr   byte address
//   wdata  write data
//   wstrb  byte enables for writes
//   rdata  read data, valid while ack is high
//   ack    one-cycle completion pulse
//   err    error flag, valid while ack is high
//   busy   responder has a transaction in flight
// Modports: master = core side, slave = responder side.

interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output rdata, ack, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - memory-side responder: data RAM plus GEN_OUT and CYCLES registers
//
// Purpose: answers the core's load/store requests with a fixed number of wait
// states. Address map: RAM at 0 .. DEPTH*4-1, GEN_OUT at 0x1000, CYCLES at 0x1004.
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst      synchronous active-high reset
//   bus      dmem_responder_if.slave (req/we/addr/wdata/wstrb in, rdata/ack/err/busy out)
//   gen_out  current GEN_OUT register value

module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1,
    parameter int OUT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    output logic [OUT_W-1:0] gen_out
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             cap_we;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;
    logic [3:0]       cap_wstrb;
    logic [OUT_W-1:0] gen_reg;
    logic [31:0]      cycles;
    logic [31:0]      mem [DEPTH];

    logic             x_we;
    logic [31:0]      x_addr;
    logic [31:0]      x_wdata;
    logic [3:0]       x_wstrb;
    logic             to_resp;
    logic             aligned;
    logic             gen_hit;
    logic             cyc_hit;
    logic             ram_hit;
    logic             bad;
    logic [AW-1:0]    ram_idx;
    logic [31:0]      read_val;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // With zero wait states the commit edge is also the accept edge, so the
    // live bus fields are used; otherwise the captured copy is authoritative.
    always_comb begin
        x_we    = cap_we;
        x_addr  = cap_addr;
        x_wdata = cap_wdata;
        x_wstrb = cap_wstrb;
        if (state == ST_IDLE) begin
            x_we    = bus.we;
            x_addr  = bus.addr;
            x_wdata = bus.wdata;
            x_wstrb = bus.wstrb;
        end
    end

    // The edge entering RESP is the commit point for writes, rdata and err.
    always_comb begin
        to_resp = 1'b0;
        if (state == ST_IDLE && bus.req && LATENCY == 0) begin
            to_resp = 1'b1;
        end
        if (state == ST_WAIT && cnt == 4'd1) begin
            to_resp = 1'b1;
        end
    end

    // Register addresses are matched first so a large RAM cannot shadow them.
    always_comb begin
        aligned = (x_addr[1:0] == 2'b00);
        gen_hit = aligned && (x_addr == 32'h0000_1000);
        cyc_hit = aligned && (x_addr == 32'h0000_1004);
        ram_hit = aligned && !gen_hit && !cyc_hit && (x_addr[31:AW+2] == '0);
        bad     = !(gen_hit || cyc_hit || ram_hit);
        ram_idx = x_addr[AW+1:2];
    end

    always_comb begin
        read_val = 32'h0;
        if (ram_hit) begin
            read_val = mem[ram_idx];
        end else if (gen_hit) begin
            read_val = 32'(gen_reg);
        end else if (cyc_hit) begin
            read_val = cycles;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            cap_we     <= 1'b0;
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
            cap_wstrb  <= 4'h0;
            gen_reg    <= '0;
            cycles     <= 32'h0;
            bus.ack    <= 1'b0;
            bus.err    <= 1'b0;
            bus.rdata  <= 32'h0;
            bus.busy   <= 1'b0;
        end else begin
            cycles    <= cycles + 32'd1;
            bus.ack   <= to_resp;
            bus.err   <= 1'b0;
            bus.rdata <= 32'h0;

            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        cap_we    <= bus.we;
                        cap_addr  <= bus.addr;
                        cap_wdata <= bus.wdata;
                        cap_wstrb <= bus.wstrb;
                        cnt       <= 4'(LATENCY);
                        bus.busy  <= 1'b1;
                        state     <= (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase

            if (to_resp) begin
                bus.err <= bad;
                if (!bad) begin
                    if (x_we) begin
                        if (gen_hit) begin
                            gen_reg <= OUT_W'(merge_bytes(32'(gen_reg), x_wdata, x_wstrb));
                        end
                        // Clearing overrides this edge's increment.
                        if (cyc_hit && x_wstrb != 4'h0) begin
                            cycles <= 32'h0;
                        end
                    end else begin
                        bus.rdata <= read_val;
                    end
                end
            end
        end
    end

    // RAM is deliberately not reset; a write interrupted by reset never commits.
    always_ff @(posedge clk) begin
        if (!rst && to_resp && ram_hit && x_we) begin
            for (int b = 0; b < 4; b++) begin
                if (x_wstrb[b]) begin
                    mem[ram_idx][8*b +: 8] <= x_wdata[8*b +: 8];
                end
            end
        end
    end

    assign gen_out = gen_reg;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the RISC_V core's load/store port: the core initiates, this block answers.
- Serves word accesses to an internal data RAM plus two memory-mapped registers:
  - GEN_OUT: the function-generator output sample.
  - CYCLES: a free-running cycle counter.
- Completes every transaction through a req/ack handshake with a configurable number of wait states.
- Sits between the core's data port and the function-generator output stage.

Parameters:
- DEPTH, 256: RAM size in 32-bit words. Power of two, 16..4096.
- LATENCY, 1: wait states between accept and ack. Range 0..15.
- OUT_W, 16: width of gen_out and of the GEN_OUT register (low bits of the word).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request valid; held high until ack.
- we  in  1  1 = write, 0 = read; stable while req is high.
- addr  in  32  byte address; stable while req is high.
- wdata  in  32  write data; stable while req is high.
- wstrb  in  4  byte enables for writes; bit i enables wdata[8i+7:8i].
- rdata  out  32  read data; valid only while ack is high.
- ack  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid only while ack is high.
- busy  out  1  high from accept through the ack cycle.
- gen_out  out  OUT_W  current GEN_OUT register value.

Behaviour:
- Reset (synchronous, active-high clk/rst as decided). Effect at the next edge:
  - FSM goes to IDLE; any pending transaction is discarded with no write committed.
  - ack=0, err=0, busy=0, rdata=0.
  - gen_out=0, CYCLES=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req=1 at an edge accepts the request. we/addr/wdata/wstrb are captured into registers, and the wait counter loads LATENCY. Next state is WAIT if LATENCY>0, else RESP.
  - WAIT: the counter decrements each cycle; when it reaches 1, next state is RESP.
  - RESP: ack=1 for exactly one cycle; next state is always IDLE.
  - A req still high in the cycle after ack is treated as a new request. The requester must drop req on the ack cycle to avoid a repeat.
- Latency:
  - With req first high in cycle 0 (accept edge ending cycle 0), ack is high in cycle LATENCY+1.
  - Maximum throughput is one transaction per LATENCY+2 cycles.
- Commit point: the edge entering RESP. At that edge:
  - the write is applied;
  - rdata and err are registered.
  - Inputs changing after accept have no effect.
- Address map. Only the captured address is used; err=1 if addr[1:0]!=0.
  - RAM, 0x0000_0000 .. DEPTH*4-1:
    - read returns mem[addr[log2(DEPTH)+1:2]];
    - write updates only the enabled bytes;
    - wstrb=0000 is a legal no-op write.
  - GEN_OUT, 0x0000_1000:
    - write updates only the enabled bytes within the low OUT_W bits;
    - read returns the value zero-extended;
    - gen_out changes on the commit edge.
  - CYCLES, 0x0000_1004:
    - increments every cycle that is not in reset; wraps 0xFFFF_FFFF -> 0;
    - read returns the value at the commit edge, before that edge's increment;
    - any write with wstrb!=0 clears it to 0; write-clear wins over the same-edge increment.
  - Any other address, or any misaligned address: err=1, rdata=0, no state change.
- When ack=0: rdata and err are held at 0.
- Reads never modify state.
- busy is 1 in WAIT and RESP, and 0 in IDLE.

Test Plan:
- LATENCY=1. Write 0xDEADBEEF to 0x10 with wstrb=1111, then read 0x10:
  - each ack arrives exactly 2 cycles after req rises;
  - the read returns 0xDEADBEEF with err=0.
- Write 0x11223344 to 0x20 with wstrb=1111, then 0xAABBCCDD with wstrb=0101, then read 0x20:
  - rdata = 0x11BB33DD.
- Write 0x0000ABCD to 0x1000:
  - gen_out = 0xABCD from the cycle after the commit edge;
  - a readback returns 0x0000ABCD.
- Write to 0x1004, then two reads back to back with req dropped on each ack:
  - the second read value minus the first equals the cycle distance between their commit edges (LATENCY+2 = 3);
  - the value is consistent with the counter having been cleared to 0 at the write's commit.
- Read 0x2000 (unmapped) and read 0x12 (misaligned):
  - ack after LATENCY+1 cycles with err=1 and rdata=0;
  - a write to 0x12 leaves RAM unchanged.
- LATENCY=3. Assert rst in the cycle after accepting a write of 0x55 to 0x0:
  - no ack; busy=0 after the reset edge;
  - a subsequent read of 0x0 returns the prior contents, not 0x55;
  - gen_out=0.
